sdram_port_arbiter: RTL and testbench

- Shares one EasySDRAM command-FIFO interface between NUM_PORTS independent requesters.
- Grants one command per cycle, round-robin, into the controller's write/full FIFO port.
- Keeps the port ID of every forwarded read in an in-order tag FIFO, so each readValid/raddr/rdata beat is routed back to the port that issued it.
- Sits between client logic (video, CPU, DMA) and the EasySDRAM instance.

---
 rtl/sdram_arb_pkg.sv | 37 +++
 rtl/sdram_tag_fifo.sv | 69 ++++++
 rtl/sdram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick helper for the EasySDRAM port arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 16;
    localparam int MASK_W    = 2;
    localparam int MAX_PORTS = 8;

    typedef struct packed {
        logic              isWrite;
        logic [MASK_W-1:0] writeMask;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] writeData;
    } sdram_req_t;

    // One-hot grant of the first set bit of valid at or after ptr, wrapping at n-1.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] valid,
        input logic [2:0]           ptr,
        input int                   n
    );
        logic [MAX_PORTS-1:0] grant;
        logic                 found;
        logic [2:0]           idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k < n && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Show-ahead FIFO holding the port ID of every read in flight to the controller.
module sdram_tag_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of one EasySDRAM command FIFO between NUM_PORTS requesters,
// with in-order tag tracking to route read returns back to the issuing port.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TAG_DEPTH = 256,
    parameter int PORT_W    = $clog2(NUM_PORTS),
    parameter int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_isWrite,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS*MASK_W-1:0] req_writeMask,
    input  logic [NUM_PORTS*DATA_W-1:0] req_writeData,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        write,
    input  logic                        full,
    output logic                        isWrite,
    output logic [ADDR_W-1:0]           address,
    output logic [MASK_W-1:0]           writeMask,
    output logic [DATA_W-1:0]           writeData,
    input  logic                        readValid,
    input  logic [ADDR_W-1:0]           raddr,
    input  logic [DATA_W-1:0]           rdata,
    output logic [CNT_W-1:0]            outstanding,
    output logic                        tag_underflow,
    output logic                        bad_mask
);

    logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                 underflow_q, underflow_d;
    logic                 bad_mask_q, bad_mask_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [MAX_PORTS-1:0] pick;
    logic [NUM_PORTS-1:0] grant;
    logic                 hs;
    logic [PORT_W-1:0]    win_idx;
    sdram_req_t           win;
    logic                 mask_ok;
    logic                 fwd_read;

    logic                 tag_push, tag_pop;
    logic [PORT_W-1:0]    tag_head;
    logic                 tag_empty, tag_full;
    logic [CNT_W-1:0]     tag_count;

    always_comb begin
        eligible = req_valid & ~{NUM_PORTS{full}} & (req_isWrite | ~{NUM_PORTS{tag_full}});
        pick     = rst ? '0 : rr_pick(MAX_PORTS'(eligible), 3'(rr_ptr_q), NUM_PORTS);
        grant    = pick[NUM_PORTS-1:0];
        hs       = |pick;
    end

    always_comb begin
        win_idx = '0;
        win     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                win_idx       = PORT_W'(i);
                win.isWrite   = req_isWrite[i];
                win.writeMask = req_writeMask[i*MASK_W +: MASK_W];
                win.address   = req_address[i*ADDR_W +: ADDR_W];
                win.writeData = req_writeData[i*DATA_W +: DATA_W];
            end
        end
    end

    // A maskless write is consumed from the port but never reaches the controller.
    assign mask_ok   = |win.writeMask;
    assign fwd_read  = hs & ~win.isWrite;
    assign write     = fwd_read | (hs & win.isWrite & mask_ok);
    assign req_ready = grant;
    assign isWrite   = win.isWrite;
    assign address   = win.address;
    assign writeMask = win.writeMask;
    assign writeData = win.writeData;

    assign tag_push = fwd_read;
    assign tag_pop  = readValid & ~tag_empty & ~rst;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (PORT_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .din   (win_idx),
        .pop   (tag_pop),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rsp_valid[i] = tag_pop && (tag_head == PORT_W'(i));
        end
    end

    assign rsp_addr      = raddr;
    assign rsp_data      = rdata;
    assign outstanding   = tag_count;
    assign tag_underflow = underflow_q;
    assign bad_mask      = bad_mask_q;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        underflow_d = underflow_q | (readValid & tag_empty);
        bad_mask_d  = bad_mask_q | (hs & win.isWrite & ~mask_ok);
        if (hs) begin
            rr_ptr_d = (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + PORT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            underflow_q <= 1'b0;
            bad_mask_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            underflow_q <= underflow_d;
            bad_mask_q  <= bad_mask_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario bench for sdram_port_arbiter; expected read-return routing kept in a scoreboard queue.
module tb_sdram_port_arbiter;

    localparam int NP  = 4;
    localparam int TD  = 256;
    localparam int CW  = $clog2(TD + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_valid, req_ready, req_isWrite;
    logic [NP*25-1:0]  req_address;
    logic [NP*2-1:0]   req_writeMask;
    logic [NP*16-1:0]  req_writeData;
    logic [NP-1:0]     rsp_valid;
    logic [24:0]       rsp_addr;
    logic [15:0]       rsp_data;
    logic              write, full, isWrite;
    logic [24:0]       address;
    logic [1:0]        writeMask;
    logic [15:0]       writeData;
    logic              readValid;
    logic [24:0]       raddr;
    logic [15:0]       rdata;
    logic [CW-1:0]     outstanding;
    logic              tag_underflow, bad_mask;

    int tests = 0;
    int fails = 0;
    logic [NP-1:0] sb_q[$];

    sdram_port_arbiter #(.NUM_PORTS(NP), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_isWrite(req_isWrite),
        .req_address(req_address), .req_writeMask(req_writeMask), .req_writeData(req_writeData),
        .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .write(write), .full(full), .isWrite(isWrite), .address(address),
        .writeMask(writeMask), .writeData(writeData),
        .readValid(readValid), .raddr(raddr), .rdata(rdata),
        .outstanding(outstanding), .tag_underflow(tag_underflow), .bad_mask(bad_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic w,
                            input logic [24:0] a, input logic [1:0] m, input logic [15:0] d);
        req_valid[p]           = v;
        req_isWrite[p]         = w;
        req_address[p*25 +: 25] = a;
        req_writeMask[p*2 +: 2] = m;
        req_writeData[p*16 +: 16] = d;
    endtask

    task automatic clear_ports();
        req_valid     = '0;
        req_isWrite   = '0;
        req_address   = '0;
        req_writeMask = '0;
        req_writeData = '0;
    endtask

    function automatic logic [NP-1:0] sb_pop();
        if (sb_q.size() == 0) return '1;
        return sb_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [NP-1:0] exp_rsp;
        rst = 1'b1;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, 25'h1000 + 25'(i), 2'b11, 16'h5000);
        readValid = 1'b1;
        #2;
        exp_rsp = '0;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write got %b want 0", write); end
        tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL reset_rsp got %b want %b", rsp_valid, exp_rsp); end
        step();
        #2;
        tests++; if (outstanding !== CW'(0)) begin fails++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        tests++; if (tag_underflow !== 1'b0 || bad_mask !== 1'b0) begin fails++; $display("FAIL reset_flags got %b%b want 00", tag_underflow, bad_mask); end
        clear_ports();
        readValid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int e;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, 25'h1000 + 25'(i), 2'b11, 16'h5000 + 16'(i));
        for (int n = 0; n < 5; n++) begin
            #2;
            e = n % NP;
            tests++; if (req_ready !== 4'(1 << e)) begin fails++; $display("FAIL rr_grant n=%0d got %b want %b", n, req_ready, 4'(1 << e)); end
            tests++; if (write !== 1'b1 || isWrite !== 1'b1) begin fails++; $display("FAIL rr_write n=%0d got %b/%b want 1/1", n, write, isWrite); end
            tests++; if (address !== 25'h1000 + 25'(e) || writeData !== 16'h5000 + 16'(e)) begin
                fails++; $display("FAIL rr_fields n=%0d got %h/%h want %h/%h", n, address, writeData, 25'h1000 + 25'(e), 16'h5000 + 16'(e));
            end
            step();
        end
        clear_ports();
    endtask

    task automatic test_read_return();
        logic [24:0] ra[3] = '{25'h100, 25'h101, 25'h200};
        logic [15:0] rd[3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        int          pp[3] = '{2, 2, 0};
        logic [NP-1:0] exp_rsp;
        for (int k = 0; k < 3; k++) begin
            clear_ports();
            set_port(pp[k], 1'b1, 1'b0, ra[k], 2'b11, 16'h0);
            #2;
            tests++; if (req_ready !== 4'(1 << pp[k]) || write !== 1'b1 || isWrite !== 1'b0 || address !== ra[k]) begin
                fails++; $display("FAIL rd_issue k=%0d got ready=%b write=%b isWrite=%b addr=%h want %b/1/0/%h",
                                  k, req_ready, write, isWrite, address, 4'(1 << pp[k]), ra[k]);
            end
            sb_q.push_back(4'(1 << pp[k]));
            step();
        end
        clear_ports();
        #2;
        tests++; if (outstanding !== CW'(3)) begin fails++; $display("FAIL rd_outstanding got %0d want 3", outstanding); end
        for (int k = 0; k < 3; k++) begin
            readValid = 1'b1; raddr = ra[k]; rdata = rd[k];
            #2;
            exp_rsp = sb_pop();
            tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL rd_route k=%0d got %b want %b", k, rsp_valid, exp_rsp); end
            tests++; if (rsp_data !== rd[k] || rsp_addr !== ra[k]) begin fails++; $display("FAIL rd_data k=%0d got %h/%h want %h/%h", k, rsp_addr, rsp_data, ra[k], rd[k]); end
            tests++; if (outstanding !== CW'(3 - k)) begin fails++; $display("FAIL rd_count k=%0d got %0d want %0d", k, outstanding, 3 - k); end
            step();
        end
        readValid = 1'b0;
        #2;
        tests++; if (outstanding !== CW'(0)) begin fails++; $display("FAIL rd_drained got %0d want 0", outstanding); end
        step();
    endtask

    // Pointer is at 1 on entry (last grant went to port 0).
    task automatic test_full_stall();
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, 25'h2000 + 25'(i), 2'b11, 16'h0);
        full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #2;
            tests++; if (req_ready !== 4'b0000 || write !== 1'b0) begin
                fails++; $display("FAIL full_stall n=%0d got ready=%b write=%b want 0000/0", n, req_ready, write);
            end
            step();
        end
        full = 1'b0;
        #2;
        tests++; if (req_ready !== 4'b0010 || write !== 1'b1 || address !== 25'h2001) begin
            fails++; $display("FAIL full_release got ready=%b write=%b addr=%h want 0010/1/2001", req_ready, write, address);
        end
        step();
        clear_ports();
    endtask

    task automatic test_tag_full();
        logic [NP-1:0] exp_rsp;
        set_port(0, 1'b1, 1'b0, 25'h4000, 2'b11, 16'h0);
        for (int k = 0; k < TD; k++) begin
            #2;
            tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL fill_grant k=%0d got %b want 0001", k, req_ready); end
            sb_q.push_back(4'b0001);
            step();
        end
        clear_ports();
        set_port(1, 1'b1, 1'b0, 25'h4100, 2'b11, 16'h0);
        set_port(3, 1'b1, 1'b1, 25'h3333, 2'b11, 16'h7777);
        #2;
        tests++; if (outstanding !== CW'(TD)) begin fails++; $display("FAIL tagfull_count got %0d want %0d", outstanding, TD); end
        tests++; if (req_ready !== 4'b1000 || write !== 1'b1 || isWrite !== 1'b1) begin
            fails++; $display("FAIL tagfull_write got ready=%b write=%b isWrite=%b want 1000/1/1", req_ready, write, isWrite);
        end
        step();
        set_port(3, 1'b0, 1'b0, 25'h0, 2'b00, 16'h0);
        readValid = 1'b1; raddr = 25'h4000; rdata = 16'h1234;
        #2;
        exp_rsp = sb_pop();
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL tagfull_stall got %b want 0000", req_ready); end
        tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL tagfull_pop got %b want %b", rsp_valid, exp_rsp); end
        step();
        readValid = 1'b0;
        #2;
        tests++; if (req_ready !== 4'b0010 || write !== 1'b1 || isWrite !== 1'b0) begin
            fails++; $display("FAIL tagfull_resume got ready=%b write=%b isWrite=%b want 0010/1/0", req_ready, write, isWrite);
        end
        sb_q.push_back(4'b0010);
        step();
        clear_ports();
        #2;
        tests++; if (outstanding !== CW'(TD)) begin fails++; $display("FAIL tagfull_refill got %0d want %0d", outstanding, TD); end
        for (int k = 0; k < TD; k++) begin
            readValid = 1'b1;
            #2;
            exp_rsp = sb_pop();
            tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL drain_route k=%0d got %b want %b", k, rsp_valid, exp_rsp); end
            step();
        end
        readValid = 1'b0;
        #2;
        tests++; if (outstanding !== CW'(0)) begin fails++; $display("FAIL drain_count got %0d want 0", outstanding); end
        step();
    endtask

    task automatic test_simul_push_pop();
        logic [NP-1:0] exp_rsp;
        set_port(2, 1'b1, 1'b0, 25'h300, 2'b11, 16'h0);
        #2;
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL pp_first got %b want 0100", req_ready); end
        sb_q.push_back(4'b0100);
        step();
        clear_ports();
        set_port(0, 1'b1, 1'b0, 25'h400, 2'b11, 16'h0);
        readValid = 1'b1; raddr = 25'h300; rdata = 16'h3030;
        #2;
        exp_rsp = sb_pop();
        tests++; if (req_ready !== 4'b0001 || write !== 1'b1) begin fails++; $display("FAIL pp_grant got ready=%b write=%b want 0001/1", req_ready, write); end
        tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL pp_route got %b want %b", rsp_valid, exp_rsp); end
        sb_q.push_back(4'b0001);
        step();
        clear_ports();
        readValid = 1'b0;
        #2;
        tests++; if (outstanding !== CW'(1)) begin fails++; $display("FAIL pp_count got %0d want 1", outstanding); end
        readValid = 1'b1; raddr = 25'h400; rdata = 16'h4040;
        #2;
        exp_rsp = sb_pop();
        tests++; if (rsp_valid !== exp_rsp) begin fails++; $display("FAIL pp_head got %b want %b", rsp_valid, exp_rsp); end
        step();
        readValid = 1'b0;
        #2;
        tests++; if (outstanding !== CW'(0)) begin fails++; $display("FAIL pp_empty got %0d want 0", outstanding); end
        step();
    endtask

    task automatic test_flags_reset();
        set_port(1, 1'b1, 1'b1, 25'h500, 2'b00, 16'hDEAD);
        #2;
        tests++; if (req_ready !== 4'b0010 || write !== 1'b0) begin
            fails++; $display("FAIL badmask_accept got ready=%b write=%b want 0010/0", req_ready, write);
        end
        step();
        clear_ports();
        #2;
        tests++; if (bad_mask !== 1'b1) begin fails++; $display("FAIL badmask_flag got %b want 1", bad_mask); end
        readValid = 1'b1;
        #2;
        tests++; if (rsp_valid !== 4'b0000) begin fails++; $display("FAIL underflow_rsp got %b want 0000", rsp_valid); end
        step();
        readValid = 1'b0;
        #2;
        tests++; if (tag_underflow !== 1'b1) begin fails++; $display("FAIL underflow_flag got %b want 1", tag_underflow); end
        set_port(0, 1'b1, 1'b0, 25'h600, 2'b11, 16'h0);
        step();
        clear_ports();
        #2;
        tests++; if (outstanding !== CW'(1)) begin fails++; $display("FAIL prereset_count got %0d want 1", outstanding); end
        rst = 1'b1;
        step();
        sb_q.delete();
        #2;
        tests++; if (outstanding !== CW'(0) || tag_underflow !== 1'b0 || bad_mask !== 1'b0) begin
            fails++; $display("FAIL reset_clear got count=%0d uf=%b bm=%b want 0/0/0", outstanding, tag_underflow, bad_mask);
        end
        rst = 1'b0;
        step();
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, 1'b1, 25'h700 + 25'(i), 2'b11, 16'h0);
        #2;
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_ptr got %b want 0001", req_ready); end
        step();
        clear_ports();
    endtask

    initial begin
        rst = 1'b1;
        full = 1'b0;
        readValid = 1'b0;
        raddr = '0;
        rdata = '0;
        clear_ports();
        step();
        test_reset();
        test_round_robin();
        test_read_return();
        test_full_stall();
        test_tag_full();
        test_simul_push_pop();
        test_flags_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
